// File: rtl/led_frame_feeder_if.sv
// Pixel stream and sender-side read port of the LED frame feeder.
// The feeder implements the slave side; the producer/sender pair drives the master side.
interface led_frame_feeder_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [23:0] fifo_data_out;
   logic        rd;
   logic        enable;

   modport slave (
      input  pix_data,
      input  pix_valid,
      input  rd,
      output pix_ready,
      output fifo_data_out,
      output enable
   );

   modport master (
      output pix_data,
      output pix_valid,
      output rd,
      input  pix_ready,
      input  fifo_data_out,
      input  enable
   );
endinterface

// File: rtl/led_frame_feeder.sv
// LED frame feeder: FWFT pixel FIFO in front of the LED serial sender, plus
// a kick scheduler that fires a one-cycle enable once a full frame is buffered,
// the refresh interval has elapsed and the previous frame (with its tail) is done.
module led_frame_feeder #(
   parameter int LED_NUM     = 4,
   parameter int DEPTH       = 16,
   parameter int REFRESH_CNT = 150000,
   parameter int TAIL_CNT    = 512
) (
   input  logic                     clk,
   input  logic                     rstn,
   led_frame_feeder_if.slave        bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              frame_cnt,
   output logic                     err_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = $clog2(REFRESH_CNT + 1);
   localparam int TW = $clog2(TAIL_CNT + 1);
   localparam int SW = $clog2(LED_NUM + 1);

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      KICK  = 2'd1,
      DRAIN = 2'd2,
      TAIL  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [23:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;

   // Scheduler state
   state_t        state_q;
   logic          enable_q;
   logic [15:0]   frame_cnt_q;
   logic [RW-1:0] refresh_q;
   logic [TW-1:0] tail_q;
   logic [SW-1:0] rd_seen_q;
   logic          err_q;

   logic          empty_s;
   logic          wr_s;
   logic          pop_s;

   assign empty_s           = (level_q == '0);
   assign bus.pix_ready     = (level_q < LW'(DEPTH));
   assign wr_s              = bus.pix_valid & bus.pix_ready;
   assign pop_s             = bus.rd & ~empty_s;
   // Head word is visible combinationally so the sender can sample it with rd.
   assign bus.fifo_data_out = empty_s ? 24'h00_0000 : mem_q[rd_ptr_q];
   assign bus.enable        = enable_q;
   assign level             = level_q;
   assign frame_cnt         = frame_cnt_q;
   assign err_underflow     = err_q;

   // Next occupancy: a write and a pop in the same cycle cancel out.
   always_comb begin
      level_d = level_q;
      case ({wr_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pixel storage; contents are don't-care while the FIFO is empty, so no reset.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_q[wr_ptr_q] <= bus.pix_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
      end
   end

   // Frame scheduler: arm, kick, count the sender's reads, then wait out the tail.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ARMED;
         enable_q    <= 1'b0;
         frame_cnt_q <= 16'd0;
         refresh_q   <= '0;
         tail_q      <= '0;
         rd_seen_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         enable_q <= 1'b0;
         // Refresh timer counts down freely and saturates at zero; a kick reloads it below.
         if (refresh_q != '0) begin
            refresh_q <= refresh_q - RW'(1);
         end
         // A read against an empty FIFO is remembered until reset.
         if (bus.rd && empty_s) begin
            err_q <= 1'b1;
         end
         case (state_q)
            ARMED: begin
               if ((level_q >= LW'(LED_NUM)) && (refresh_q == '0)) begin
                  state_q     <= KICK;
                  enable_q    <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  refresh_q   <= RW'(REFRESH_CNT - 1);
               end
            end
            KICK: begin
               rd_seen_q <= '0;
               state_q   <= DRAIN;
            end
            DRAIN: begin
               // Underflow reads still count: the sender believes it consumed a pixel.
               if (bus.rd) begin
                  if (rd_seen_q == SW'(LED_NUM - 1)) begin
                     tail_q  <= TW'(TAIL_CNT - 1);
                     state_q <= TAIL;
                  end else begin
                     rd_seen_q <= rd_seen_q + SW'(1);
                  end
               end
            end
            TAIL: begin
               if (tail_q == '0) begin
                  state_q <= ARMED;
               end else begin
                  tail_q <= tail_q - TW'(1);
               end
            end
            default: begin
               state_q <= ARMED;
            end
         endcase
      end
   end

endmodule
